// File: rtl/counter_pkg.sv
// Shared constants and state encoding for the up/down modulo counter.
package counter_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [0:0] {
    ST_COUNT  = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: asserts tick on the enabled cycle that completes a PRESCALE-cycle period.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] Last = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with prescaler, load/clear and one-shot halt.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic             running
);

  // Explicit terminal value so MODULO == 2**WIDTH never relies on overflow.
  localparam logic [WIDTH-1:0] Max = WIDTH'(MODULO - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             tick;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en && (state_q == ST_COUNT)),
    .sync_clr (clear || load),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    if (clear) begin
      out_d   = '0;
      state_d = ST_COUNT;
    end else if (load) begin
      out_d   = (load_val > Max) ? Max : load_val;
      state_d = ST_COUNT;
    end else if (state_q == ST_COUNT && tick) begin
      if (up_dn == DIR_UP) begin
        if (out_q == Max) begin
          tc_d = 1'b1;
          if (mode == MODE_ONESHOT) state_d = ST_HALTED;
          else                      out_d   = '0;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          tc_d = 1'b1;
          if (mode == MODE_ONESHOT) state_d = ST_HALTED;
          else                      out_d   = Max;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COUNT;
      out_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
    end
  end

  assign out     = out_q;
  assign tc      = tc_q;
  assign done    = (state_q == ST_HALTED);
  assign running = (state_q == ST_COUNT);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: two counter configurations share random stimulus and are checked
// against an arithmetic reference model.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, mode, clear, load;
  logic [3:0] load_val;
  logic [3:0] out0, out1;
  logic       tc0, tc1, done0, done1, run0, run1;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .clear(clear),
    .load(load), .load_val(load_val), .out(out0), .tc(tc0), .done(done0), .running(run0)
  );

  counter_updown_mod #(.WIDTH(4), .MODULO(16), .PRESCALE(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .clear(clear),
    .load(load), .load_val(load_val), .out(out1), .tc(tc1), .done(done1), .running(run1)
  );

  typedef struct {
    int out;
    bit tc;
    bit done;
    bit running;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int mods[2] = '{10, 16};
  int pres[2] = '{1, 3};
  int m_cnt[2];
  int m_pre[2];
  bit m_halt[2];
  bit m_tc[2];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  // Reference model: one clock edge worth of the counter rules, using plain arithmetic.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst || clear) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_halt[k] = 0; m_tc[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) >= mods[k]) ? mods[k] - 1 : int'(load_val);
        m_pre[k] = 0; m_halt[k] = 0; m_tc[k] = 0;
      end else begin
        m_tc[k] = 0;
        if (!m_halt[k] && en) begin
          m_pre[k] = (m_pre[k] + 1) % pres[k];
          if (m_pre[k] == 0) begin
            int nxt;
            nxt = up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
            if (nxt < 0 || nxt >= mods[k]) begin
              m_tc[k] = 1;
              if (mode) m_halt[k] = 1;
              else      m_cnt[k] = (nxt + mods[k]) % mods[k];
            end else begin
              m_cnt[k] = nxt;
            end
          end
        end
      end
    end
    q0.push_back('{out: m_cnt[0], tc: m_tc[0], done: m_halt[0], running: !m_halt[0]});
    q1.push_back('{out: m_cnt[1], tc: m_tc[1], done: m_halt[1], running: !m_halt[1]});
  endtask

  task automatic cyc(input bit r, input bit c, input bit l, input bit e, input bit u,
                     input bit m, input logic [3:0] lv);
    @(negedge clk);
    rst = r; clear = c; load = l; en = e; up_dn = u; mode = m; load_val = lv;
    model_edge();
  endtask

  task automatic run(input int n, input bit e, input bit u, input bit m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, e, u, m, 4'd0);
  endtask

  // Monitor: every edge presents a new output set; compare against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("d0.out", int'(out0), e.out);
      check("d0.tc", int'(tc0), int'(e.tc));
      check("d0.done", int'(done0), int'(e.done));
      check("d0.running", int'(run0), int'(e.running));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("d1.out", int'(out1), e.out);
      check("d1.tc", int'(tc1), int'(e.tc));
      check("d1.done", int'(done1), int'(e.done));
      check("d1.running", int'(run1), int'(e.running));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 1'b0; clear = 1'b0; load = 1'b0;
    load_val = '0;
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    run(14, 1, 1, 0);                       // up, wrap
    cyc(0, 0, 1, 1, 0, 0, 4'd3);            // load 3, then down through wrap
    run(8, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 1, 4'd7);            // one-shot up from 7
    run(8, 1, 1, 1);
    run(3, 1, 1, 0);                        // mode back to wrap while halted
    cyc(0, 1, 0, 1, 1, 0, 0);               // clear
    run(4, 1, 1, 0);
    run(2, 0, 1, 0);                        // en dropped mid-prescale
    run(4, 1, 0, 0);                        // direction change mid-prescale
    cyc(0, 0, 1, 1, 1, 0, 4'd12);           // clamp
    cyc(0, 1, 1, 1, 1, 0, 4'd5);            // clear beats load
    cyc(0, 0, 1, 1, 1, 0, 4'd8);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 4'd5);            // load on a terminal-step cycle
    run(3, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 1, 4'd9);
    run(4, 1, 1, 1);
    cyc(1, 0, 0, 1, 1, 1, 0);               // reset while halted
    run(5, 1, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
          ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 80),
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
          4'($urandom_range(0, 15)));
    end
    @(posedge clk);
    #3;
    check("queue0.drained", q0.size(), 0);
    check("queue1.drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
